elastic_fifo: RTL and testbench
===============================

# elastic_fifo

Parametrised successor to the two-entry skid buffer: a valid/ready elastic buffer of configurable depth with a registered output stage, an occupancy count, an almost-full flag and a synchronous flush. It sits between AXI-Stream/AXI-Lite channel stages where more than two words of slack are needed. It sustains one transfer per cycle in both directions and has no combinational path from `out_ready` to `in_ready` or from `in_valid` to `out_valid`. With `DEPTH = 2` it is cycle-equivalent to the skid buffer.

## Interface
- `DATA_WIDTH`, 32: payload width in bits.
- `DEPTH`, 4: total capacity in words (output register plus DEPTH-1 storage entries); legal range ≥ 2, no power-of-two requirement.
- `ALMOST_FULL_LEVEL`, DEPTH-1: `almost_full` asserts when `level` ≥ this value; legal range 1..DEPTH.
- `LW` (localparam) = $clog2(DEPTH+1).

Ports:
- `clk` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `flush` in 1: synchronous discard of all contents.
- `in_data` in DATA_WIDTH: upstream payload.
- `in_valid` in 1: upstream valid.
- `in_ready` out 1: buffer can accept.
- `out_data` out DATA_WIDTH: registered head-of-queue payload.
- `out_valid` out 1: head word present.
- `out_ready` in 1: downstream accepts.
- `level` out LW: current occupancy 0..DEPTH.
- `almost_full` out 1: `level` ≥ ALMOST_FULL_LEVEL.

## Operation
- rx = in_valid && in_ready; tx = out_valid && out_ready.
- State: `level` register, output register `out_data` with implicit valid (level ≠ 0), storage array of DEPTH-1 entries with `wr_ptr` and `rd_ptr`. Pointers range 0..DEPTH-2 and wrap explicitly from DEPTH-2 to 0. The storage count is max(level-1, 0).
- `in_ready` = (level ≠ DEPTH) && !reset. `out_valid` = (level ≠ 0). Both are decoded from registers only.
- Data routing, with flush/reset inactive:
  - rx, no tx, level = 0 (load): `out_data` ← `in_data`.
  - rx, no tx, level ≥ 1 (fill): storage[wr_ptr] ← `in_data`; wr_ptr advances.
  - tx, no rx, level ≥ 2 (drain): `out_data` ← storage[rd_ptr]; rd_ptr advances.
  - tx, no rx, level = 1 (unload): `out_data` holds; valid drops.
  - rx and tx, level = 1 (flow): `out_data` ← `in_data`.
  - rx and tx, level ≥ 2 (cycle): `out_data` ← storage[rd_ptr] and storage[wr_ptr] ← `in_data`; both pointers advance. This is legal when level = DEPTH only if in_ready = 0, so it never occurs there.
- `level` next = level + rx − tx. It never exceeds DEPTH and never underflows.
- Ordering: words leave in strict acceptance order; no word is duplicated or dropped except by flush/reset.
- `out_data` is stable while out_valid && !out_ready. It is don't-care while out_valid = 0 and has no reset.
- Flush (flush = 1, reset = 0): next cycle level = 0 and wr_ptr = rd_ptr = 0. A tx in the flush cycle counts as delivered. A word accepted by rx in the flush cycle is discarded. `in_ready`/`out_valid` are not gated by flush in the flush cycle.
- Reset has priority over flush and over all handshakes. Storage contents are not reset.

## Timing
- Reset values (cycle after reset sampled high): level = 0, out_valid = 0, almost_full = 0, wr_ptr = rd_ptr = 0. `in_ready` = 0 while reset is high and 1 the cycle after release.
- Latency: a word accepted into an empty buffer at edge N is presented on `out_data`/`out_valid` after edge N (one cycle).
- Throughput: with in_valid and out_ready held high, one word per cycle indefinitely at any level 1..DEPTH-1.
- Backpressure: `in_ready` falls the cycle after the rx that makes level = DEPTH. It rises the cycle after the first tx from full.
- `level` and `almost_full` reflect state after the last edge; they are combinational from the `level` register only.
- Reset mid-transfer: all held words are lost and no tx is reported after reset. The same applies to flush.

## Test plan
- Fill/drain, DEPTH=4, out_ready=0: send 0xA0..0xA4 → 0xA0..0xA3 accepted, in_ready low after 4th, level=4, almost_full=1 at level 3. Then out_ready=1 → outputs 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, then out_valid=0.
- Streaming: in_valid and out_ready held high for 20 words 0..19 → out_data 0..19 one per cycle after 1-cycle latency, level constant 1.
- Pointer wrap, DEPTH=5: random in_valid/out_ready (50%) for 1000 words → scoreboard shows exact order and no loss. level always equals accepted − delivered.
- Simultaneous rx/tx at level=3 (DEPTH=4) → level stays 3, out_data advances to next stored word, new word appended at tail.
- Flush at level=3 with concurrent rx of 0xBB → next cycle level=0, out_valid=0. A subsequent word 0xCC is output first, and 0xBB never appears.
- Reset asserted mid-stream at level=2 → in_ready=0 during reset. After release level=0, out_valid=0, in_ready=1, and the next accepted word appears after one cycle.

Source files
------------

// File: rtl/elastic_fifo.sv
// Valid/ready elastic buffer: registered output word plus a DEPTH-1 entry circular
// store, with occupancy count, almost-full flag and synchronous flush.
module elastic_fifo #(
  parameter int DATA_WIDTH        = 32,
  parameter int DEPTH             = 4,
  parameter int ALMOST_FULL_LEVEL = DEPTH - 1,
  localparam int LW               = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LW-1:0]         level,
  output logic                  almost_full
);

  localparam int SD = DEPTH - 1;
  localparam int PW = (SD > 1) ? $clog2(SD) : 1;

  logic [LW-1:0]         level_q, level_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0] mem_q [SD];

  logic rx, tx, load_in, wr_en, rd_adv;

  // Explicit wrap so SD need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(SD - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready    = (level_q != LW'(DEPTH)) && !reset;
  assign out_valid   = (level_q != '0);
  assign out_data    = out_data_q;
  assign level       = level_q;
  assign almost_full = (level_q >= LW'(ALMOST_FULL_LEVEL));

  always_comb begin
    rx = in_valid && in_ready;
    tx = out_valid && out_ready;
    // Incoming word goes straight to the output register when it would be the head.
    load_in = rx && ((level_q == '0) || ((level_q == LW'(1)) && tx));
    wr_en   = rx && !load_in;
    rd_adv  = tx && (level_q >= LW'(2));

    level_d    = level_q + LW'(rx) - LW'(tx);
    wr_ptr_d   = wr_en  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = rd_adv ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    out_data_d = out_data_q;
    if (load_in) begin
      out_data_d = in_data;
    end else if (rd_adv) begin
      out_data_d = mem_q[rd_ptr_q];
    end

    if (flush) begin
      level_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload path carries no reset; validity is tracked solely by level_q.
  always_ff @(posedge clk) begin
    out_data_q <= out_data_d;
    if (wr_en && !flush) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_elastic_fifo.sv
// Directed vector table plus hand-written sequences for elastic_fifo (DEPTH=4),
// and a randomised scoreboard run on a DEPTH=5 instance.
module tb_elastic_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  level;
  logic        almost_full;

  logic        flush5 = 1'b0;
  logic [31:0] in_data5 = '0;
  logic        in_valid5 = 1'b0;
  logic        in_ready5;
  logic [31:0] out_data5;
  logic        out_valid5;
  logic        out_ready5 = 1'b0;
  logic [2:0]  level5;
  logic        almost_full5;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  elastic_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .almost_full(almost_full)
  );

  elastic_fifo #(.DATA_WIDTH(32), .DEPTH(5)) dut5 (
    .clk(clk), .reset(reset), .flush(flush5),
    .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_valid(out_valid5), .out_ready(out_ready5),
    .level(level5), .almost_full(almost_full5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        fl;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_data;
    int          e_lvl;
    logic        e_af;
  } vec_t;

  vec_t vecs [25];

  initial begin
    int   mlevel;
    int   sent;
    int   got;
    logic rx;
    logic tx;
    logic [31:0] q [$];

    // Expected outputs are the state seen before the edge on which the inputs apply.
    //            fl iv d       ordy ir ov data     lvl af
    vecs[0]  = '{0, 1, 32'hA0, 0,   1, 0, 32'h0,   0, 0};
    vecs[1]  = '{0, 1, 32'hA1, 0,   1, 1, 32'hA0,  1, 0};
    vecs[2]  = '{0, 1, 32'hA2, 0,   1, 1, 32'hA0,  2, 0};
    vecs[3]  = '{0, 1, 32'hA3, 0,   1, 1, 32'hA0,  3, 1};
    vecs[4]  = '{0, 1, 32'hA4, 0,   0, 1, 32'hA0,  4, 1};
    vecs[5]  = '{0, 1, 32'hA4, 1,   0, 1, 32'hA0,  4, 1};
    vecs[6]  = '{0, 0, 32'h0,  1,   1, 1, 32'hA1,  3, 1};
    vecs[7]  = '{0, 0, 32'h0,  1,   1, 1, 32'hA2,  2, 0};
    vecs[8]  = '{0, 0, 32'h0,  1,   1, 1, 32'hA3,  1, 0};
    vecs[9]  = '{0, 0, 32'h0,  0,   1, 0, 32'h0,   0, 0};
    vecs[10] = '{0, 1, 32'hB1, 0,   1, 0, 32'h0,   0, 0};
    vecs[11] = '{0, 1, 32'hB2, 0,   1, 1, 32'hB1,  1, 0};
    vecs[12] = '{0, 1, 32'hB3, 0,   1, 1, 32'hB1,  2, 0};
    vecs[13] = '{0, 1, 32'hB4, 1,   1, 1, 32'hB1,  3, 1};
    vecs[14] = '{0, 0, 32'h0,  1,   1, 1, 32'hB2,  3, 1};
    vecs[15] = '{0, 0, 32'h0,  1,   1, 1, 32'hB3,  2, 0};
    vecs[16] = '{0, 0, 32'h0,  1,   1, 1, 32'hB4,  1, 0};
    vecs[17] = '{0, 0, 32'h0,  0,   1, 0, 32'h0,   0, 0};
    vecs[18] = '{0, 1, 32'hC1, 0,   1, 0, 32'h0,   0, 0};
    vecs[19] = '{0, 1, 32'hC2, 0,   1, 1, 32'hC1,  1, 0};
    vecs[20] = '{0, 1, 32'hC3, 0,   1, 1, 32'hC1,  2, 0};
    vecs[21] = '{1, 1, 32'hBB, 0,   1, 1, 32'hC1,  3, 1};
    vecs[22] = '{0, 1, 32'hCC, 0,   1, 0, 32'h0,   0, 0};
    vecs[23] = '{0, 0, 32'h0,  1,   1, 1, 32'hCC,  1, 0};
    vecs[24] = '{0, 0, 32'h0,  0,   1, 0, 32'h0,   0, 0};

    // Power-on reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_almost_full", 32'(almost_full), 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      flush     = vecs[i].fl;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      #1;
      $display("vec %0d: fl=%0d iv=%0d d=%0h ordy=%0d -> ir=%0d ov=%0d out=%0h lvl=%0d af=%0d",
               i, flush, in_valid, in_data, out_ready, in_ready, out_valid, out_data, level, almost_full);
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].e_lvl));
      chk($sformatf("vec%0d_almost_full", i), 32'(almost_full), 32'(vecs[i].e_af));
      if (vecs[i].e_ov)
        chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_data);
    end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    // Streaming: one word per cycle at constant level 1
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'(i); out_ready = 1'b1;
      #1;
      $display("stream %0d: out=%0h ov=%0d lvl=%0d", i, out_data, out_valid, level);
      if (i == 0) begin
        chk("stream_level0", 32'(level), 32'd0);
      end else begin
        chk("stream_level", 32'(level), 32'd1);
        chk("stream_out_valid", 32'(out_valid), 32'd1);
        chk("stream_out_data", out_data, 32'(i - 1));
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("stream_last_data", out_data, 32'd19);
    chk("stream_last_level", 32'(level), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("stream_empty_level", 32'(level), 32'd0);
    chk("stream_empty_valid", 32'(out_valid), 32'd0);

    // Reset mid-stream at level 2
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'hD0;
    @(negedge clk);
    in_data = 32'hD1;
    @(negedge clk);
    in_data = 32'hD2; reset = 1'b1;
    #1;
    $display("reset mid-stream: lvl=%0d ir=%0d", level, in_ready);
    chk("midrst_level_before", 32'(level), 32'd2);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("midrst_in_ready_held", 32'(in_ready), 32'd0);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    reset = 1'b0; in_data = 32'hE0;
    #1;
    chk("postrst_in_ready", 32'(in_ready), 32'd1);
    chk("postrst_level", 32'(level), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    $display("post-reset word: out=%0h ov=%0d lvl=%0d", out_data, out_valid, level);
    chk("postrst_out_valid", 32'(out_valid), 32'd1);
    chk("postrst_out_data", out_data, 32'hE0);
    chk("postrst_level1", 32'(level), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("postrst_drained", 32'(level), 32'd0);

    // Random handshakes on DEPTH=5 against a queue model
    mlevel = 0; sent = 0; got = 0;
    for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
      @(negedge clk);
      in_valid5  = ($urandom_range(0, 1) == 1) && (sent < 1000);
      in_data5   = 32'(sent) ^ 32'h5A00_0000;
      out_ready5 = ($urandom_range(0, 1) == 1);
      #1;
      chk("rand_level", 32'(level5), 32'(mlevel));
      chk("rand_in_ready", 32'(in_ready5), 32'(mlevel != 5));
      chk("rand_out_valid", 32'(out_valid5), 32'(mlevel != 0));
      chk("rand_almost_full", 32'(almost_full5), 32'(mlevel >= 4));
      rx = in_valid5 && (mlevel != 5);
      tx = out_ready5 && (mlevel != 0);
      if (tx) begin
        chk("rand_out_data", out_data5, q[0]);
        void'(q.pop_front());
        got++;
      end
      if (rx) begin
        q.push_back(in_data5);
        sent++;
      end
      mlevel = mlevel + int'(rx) - int'(tx);
    end
    in_valid5 = 1'b0; out_ready5 = 1'b0;
    $display("random run: sent=%0d delivered=%0d", sent, got);
    chk("rand_delivered", 32'(got), 32'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
